// File: rtl/tlul_host_arbiter.sv
// tlul_host_arbiter: N-host to 1-device TL-UL arbiter.
// Round-robin A-channel grant, locked while a granted beat is stalled.
// The host index is tagged into the top IDW bits of a_source, and D responses
// are steered back by those same bits. Each host has an outstanding-request limit.
// Optional build macro TLUL_ARB_PERF_EN adds per-host saturating grant
// counters (perf_grant_o) and their synchronous clear (perf_clr_i).

package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_SZW = 2;

  localparam logic [2:0] PutFullData   = 3'h0;
  localparam logic [2:0] Get           = 3'h4;
  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

// Per-host outstanding counter; full gates new grants for that host.
module tlul_arb_host_cnt #(
  parameter int MAX_OUTS = 2,
  parameter int CW       = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_acc,
  input  logic d_acc,
  output logic full
);
  logic [CW-1:0] cnt;

  // Count A accepts up, D accepts down; simultaneous events cancel; no underflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              cnt <= '0;
    else if (a_acc && !d_acc)               cnt <= cnt + CW'(1);
    else if (d_acc && !a_acc && cnt != '0)  cnt <= cnt - CW'(1);
  end

  assign full = (cnt == CW'(MAX_OUTS));
endmodule

module tlul_host_arbiter
  import tlul_pkg::*;
#(
  parameter int NUM_HOSTS = 4,
  parameter int MAX_OUTS  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  tl_h2d_t              tl_h_i [NUM_HOSTS],
  output tl_d2h_t              tl_h_o [NUM_HOSTS],
  output tl_h2d_t              tl_d_o,
  input  tl_d2h_t              tl_d_i,
  output logic [NUM_HOSTS-1:0] outs_full_o
`ifdef TLUL_ARB_PERF_EN
  , input  logic                       perf_clr_i
  , output logic [NUM_HOSTS-1:0][15:0] perf_grant_o
`endif
);
  localparam int IDW = $clog2(NUM_HOSTS);
  localparam int CW  = $clog2(MAX_OUTS + 1);

  logic [IDW-1:0]       rr_ptr, lock_idx, rr_idx, grant, d_idx;
  logic                 lock_q, rr_found, gnt_vld, a_vld, d_rdy_sel, dev_d_ready;
  logic [NUM_HOSTS-1:0] elig, full, a_acc, d_acc;
  tl_h2d_t              a_sel;

  // Per-host outstanding limit tracking.
  for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_host
    assign elig[g] = tl_h_i[g].a_valid & ~full[g];
    assign a_acc[g] = a_vld & tl_d_i.a_ready & (grant == IDW'(g));
    assign d_acc[g] = tl_h_o[g].d_valid & tl_h_i[g].d_ready;
    tlul_arb_host_cnt #(.MAX_OUTS(MAX_OUTS), .CW(CW)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .a_acc (a_acc[g]),
      .d_acc (d_acc[g]),
      .full  (full[g])
    );
  end

  assign outs_full_o = rst_i ? '0 : full;

  // Round-robin search: first eligible host after rr_ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_HOSTS; k++) begin
      for (int i = 0; i < NUM_HOSTS; i++) begin
        if (!rr_found && elig[i] && ((int'(rr_ptr) + k) % NUM_HOSTS) == i) begin
          rr_found = 1'b1;
          rr_idx   = IDW'(i);
        end
      end
    end
  end

  // A stalled beat pins the grant until it is accepted.
  assign grant   = lock_q ? lock_idx : rr_idx;
  assign gnt_vld = lock_q | rr_found;

  // Select the granted host's request.
  always_comb begin
    a_sel = '0;
    for (int i = 0; i < NUM_HOSTS; i++)
      if (grant == IDW'(i)) a_sel = tl_h_i[i];
  end

  assign a_vld = gnt_vld & a_sel.a_valid & ~rst_i;

  // Device request: granted A fields with host ID in the top source bits.
  always_comb begin
    tl_d_o          = a_sel;
    tl_d_o.a_valid  = a_vld;
    tl_d_o.a_source = {grant, a_sel.a_source[TL_AIW-IDW-1:0]};
    tl_d_o.d_ready  = dev_d_ready;
  end

  // D route: source ID picks the host; IDs with no host are sunk (ready = 1).
  assign d_idx = tl_d_i.d_source[TL_AIW-1 -: IDW];

  always_comb begin
    d_rdy_sel = 1'b1;
    for (int i = 0; i < NUM_HOSTS; i++)
      if (d_idx == IDW'(i)) d_rdy_sel = tl_h_i[i].d_ready;
  end

  assign dev_d_ready = d_rdy_sel & ~rst_i;

  // Host responses: D fields to the addressed host, a_ready to the granted host.
  always_comb begin
    for (int i = 0; i < NUM_HOSTS; i++) begin
      tl_h_o[i]                              = tl_d_i;
      tl_h_o[i].d_source[TL_AIW-1 -: IDW]    = '0;
      tl_h_o[i].d_valid = tl_d_i.d_valid & (d_idx == IDW'(i)) & ~rst_i;
      tl_h_o[i].a_ready = tl_d_i.a_ready & gnt_vld & (grant == IDW'(i)) & ~rst_i;
    end
  end

  // Lock on a stalled beat; advance the round-robin pointer on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= IDW'(NUM_HOSTS - 1);
      lock_q   <= 1'b0;
      lock_idx <= '0;
    end else if (a_vld && tl_d_i.a_ready) begin
      lock_q   <= 1'b0;
      rr_ptr   <= grant;
    end else if (a_vld) begin
      lock_q   <= 1'b1;
      lock_idx <= grant;
    end
  end

`ifdef TLUL_ARB_PERF_EN
  for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_perf
    // Saturating per-host grant counter; clear wins over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                      perf_grant_o[g] <= '0;
      else if (perf_clr_i)                            perf_grant_o[g] <= '0;
      else if (a_acc[g] && perf_grant_o[g] != 16'hFFFF) perf_grant_o[g] <= perf_grant_o[g] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Directed bench for tlul_host_arbiter (NUM_HOSTS=4, MAX_OUTS=2, 8-bit source).
module tb_tlul_host_arbiter;
  import tlul_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  tl_h2d_t  h_req [4];
  tl_d2h_t  h_rsp [4];
  tl_h2d_t  d_req;
  tl_d2h_t  d_rsp;
  logic [3:0] full;
  int checks = 0;
  int failures = 0;

  tlul_host_arbiter #(.NUM_HOSTS(4), .MAX_OUTS(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_h_i      (h_req),
    .tl_h_o      (h_rsp),
    .tl_d_o      (d_req),
    .tl_d_i      (d_rsp),
    .outs_full_o (full)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    for (int i = 0; i < 4; i++) begin
      h_req[i] = '0;
      h_req[i].d_ready = 1'b1;
    end
    d_rsp = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] ar_vec();
    for (int i = 0; i < 4; i++) ar_vec[i] = h_rsp[i].a_ready;
  endfunction

  function automatic logic [3:0] dv_vec();
    for (int i = 0; i < 4; i++) dv_vec[i] = h_rsp[i].d_valid;
  endfunction

  task automatic test_reset();
    clr_in();
    for (int i = 0; i < 4; i++) begin
      h_req[i].a_valid = 1'b1;
      h_req[i].a_opcode = Get;
    end
    d_rsp.a_ready = 1'b1;
    d_rsp.d_valid = 1'b1;
    rst = 1'b1;
    #2;
    checks++; if (d_req.a_valid !== 1'b0) begin failures++; $display("FAIL rst_a_valid got=%b exp=0", d_req.a_valid); end
    checks++; if (d_req.d_ready !== 1'b0) begin failures++; $display("FAIL rst_d_ready got=%b exp=0", d_req.d_ready); end
    checks++; if (ar_vec() !== 4'b0 || dv_vec() !== 4'b0) begin failures++; $display("FAIL rst_host got ar=%b dv=%b exp 0", ar_vec(), dv_vec()); end
    checks++; if (full !== 4'b0) begin failures++; $display("FAIL rst_full got=%b exp=0000", full); end
    tick();
    rst = 1'b0;
    d_rsp.d_valid = 1'b0;
    #1;
    checks++; if (d_req.a_source !== 8'h00 || ar_vec() !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got src=%h ar=%b exp src=00 ar=0001", d_req.a_source, ar_vec()); end
    tick();
    clr_in();
  endtask

  task automatic test_round_robin();
    int g;
    logic [7:0] exp_src;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      h_req[i].a_valid   = 1'b1;
      h_req[i].a_opcode  = Get;
      h_req[i].a_source  = 8'(i + 1);
      h_req[i].a_address = 32'(32'h100 * i);
    end
    d_rsp.a_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      g = c % 4;
      exp_src = 8'(g * 64 + g + 1);
      d_rsp.d_valid  = 1'b1;
      d_rsp.d_opcode = AccessAckData;
      d_rsp.d_source = 8'(g * 64);
      #1;
      checks++; if (d_req.a_valid !== 1'b1 || d_req.a_source !== exp_src) begin failures++; $display("FAIL rr_src cyc=%0d got v=%b src=%h exp v=1 src=%h", c, d_req.a_valid, d_req.a_source, exp_src); end
      checks++; if (d_req.a_address !== 32'(32'h100 * g)) begin failures++; $display("FAIL rr_addr cyc=%0d got=%h exp=%h", c, d_req.a_address, 32'(32'h100 * g)); end
      checks++; if (ar_vec() !== 4'(1 << g) || dv_vec() !== 4'(1 << g)) begin failures++; $display("FAIL rr_host cyc=%0d got ar=%b dv=%b exp=%b", c, ar_vec(), dv_vec(), 4'(1 << g)); end
      tick();
    end
    clr_in();
  endtask

  task automatic test_lock();
    do_reset();
    h_req[2].a_valid   = 1'b1;
    h_req[2].a_opcode  = Get;
    h_req[2].a_source  = 8'h05;
    h_req[2].a_address = 32'h2000;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin
        h_req[1].a_valid  = 1'b1;
        h_req[1].a_opcode = Get;
        h_req[1].a_source = 8'h11;
      end
      d_rsp.a_ready = (c == 3);
      #1;
      checks++; if (d_req.a_valid !== 1'b1 || d_req.a_source !== 8'h85) begin failures++; $display("FAIL lock_src cyc=%0d got v=%b src=%h exp v=1 src=85", c, d_req.a_valid, d_req.a_source); end
      checks++; if (h_rsp[1].a_ready !== 1'b0 || h_rsp[2].a_ready !== (c == 3)) begin failures++; $display("FAIL lock_ready cyc=%0d got h1=%b h2=%b", c, h_rsp[1].a_ready, h_rsp[2].a_ready); end
      tick();
    end
    h_req[2].a_valid = 1'b0;
    #1;
    checks++; if (d_req.a_source !== 8'h51 || h_rsp[1].a_ready !== 1'b1) begin failures++; $display("FAIL lock_release got src=%h h1=%b exp src=51 h1=1", d_req.a_source, h_rsp[1].a_ready); end
    tick();
    clr_in();
  endtask

  task automatic test_outs_limit();
    do_reset();
    h_req[0].a_valid  = 1'b1;
    h_req[0].a_opcode = Get;
    d_rsp.a_ready = 1'b1;
    #1;
    checks++; if (h_rsp[0].a_ready !== 1'b1 || full !== 4'b0) begin failures++; $display("FAIL lim_first got ar=%b full=%b", h_rsp[0].a_ready, full); end
    tick();
    checks++; if (h_rsp[0].a_ready !== 1'b1) begin failures++; $display("FAIL lim_second got=%b exp=1", h_rsp[0].a_ready); end
    tick();
    h_req[1].a_valid  = 1'b1;
    h_req[1].a_opcode = Get;
    h_req[1].a_source = 8'h02;
    #1;
    checks++; if (full !== 4'b0001) begin failures++; $display("FAIL lim_full got=%b exp=0001", full); end
    checks++; if (h_rsp[0].a_ready !== 1'b0 || d_req.a_source !== 8'h42) begin failures++; $display("FAIL lim_block got h0=%b src=%h exp h0=0 src=42", h_rsp[0].a_ready, d_req.a_source); end
    tick();
    h_req[1].a_valid = 1'b0;
    d_rsp.d_valid  = 1'b1;
    d_rsp.d_opcode = AccessAckData;
    d_rsp.d_source = 8'h00;
    d_rsp.d_data   = 32'hCAFE0000;
    #1;
    checks++; if (d_req.a_valid !== 1'b0 || h_rsp[0].d_valid !== 1'b1) begin failures++; $display("FAIL lim_resp got av=%b dv=%b exp av=0 dv=1", d_req.a_valid, h_rsp[0].d_valid); end
    tick();
    d_rsp.d_valid = 1'b0;
    #1;
    checks++; if (full !== 4'b0 || d_req.a_valid !== 1'b1 || d_req.a_source !== 8'h00 || h_rsp[0].a_ready !== 1'b1) begin failures++; $display("FAIL lim_third got full=%b av=%b src=%h ar=%b", full, d_req.a_valid, d_req.a_source, h_rsp[0].a_ready); end
    tick();
    h_req[0].a_valid = 1'b0;
    #1;
    checks++; if (full !== 4'b0001) begin failures++; $display("FAIL lim_refull got=%b exp=0001", full); end
    clr_in();
  endtask

  task automatic test_d_route();
    do_reset();
    h_req[1].a_valid  = 1'b1;
    h_req[1].a_opcode = Get;
    h_req[1].a_source = 8'h03;
    d_rsp.a_ready = 1'b1;
    tick();
    tick();
    h_req[1].a_valid = 1'b0;
    h_req[1].d_ready = 1'b0;
    d_rsp.d_valid  = 1'b1;
    d_rsp.d_opcode = AccessAckData;
    d_rsp.d_source = 8'h43;
    d_rsp.d_data   = 32'h12345678;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (dv_vec() !== 4'b0010 || h_rsp[1].d_source !== 8'h03 || h_rsp[1].d_data !== 32'h12345678) begin failures++; $display("FAIL droute cyc=%0d got dv=%b src=%h data=%h", c, dv_vec(), h_rsp[1].d_source, h_rsp[1].d_data); end
      checks++; if (d_req.d_ready !== 1'b0 || full !== 4'b0010) begin failures++; $display("FAIL droute_stall cyc=%0d got rdy=%b full=%b exp rdy=0 full=0010", c, d_req.d_ready, full); end
      tick();
    end
    h_req[1].d_ready = 1'b1;
    #1;
    checks++; if (d_req.d_ready !== 1'b1) begin failures++; $display("FAIL droute_ready got=%b exp=1", d_req.d_ready); end
    tick();
    d_rsp.d_valid = 1'b0;
    #1;
    checks++; if (full !== 4'b0) begin failures++; $display("FAIL droute_dec got=%b exp=0000", full); end
    h_req[1].a_valid = 1'b1;
    tick();
    h_req[1].a_valid = 1'b0;
    #1;
    checks++; if (full !== 4'b0010) begin failures++; $display("FAIL droute_once got=%b exp=0010", full); end
    clr_in();
  endtask

  task automatic test_same_cycle();
    do_reset();
    h_req[3].a_valid  = 1'b1;
    h_req[3].a_opcode = Get;
    h_req[3].a_source = 8'h07;
    d_rsp.a_ready = 1'b1;
    #1;
    checks++; if (h_rsp[3].a_ready !== 1'b1 || d_req.a_source !== 8'hC7) begin failures++; $display("FAIL same_first got ar=%b src=%h exp ar=1 src=C7", h_rsp[3].a_ready, d_req.a_source); end
    tick();
    d_rsp.d_valid  = 1'b1;
    d_rsp.d_source = 8'hC0;
    #1;
    checks++; if (h_rsp[3].a_ready !== 1'b1 || h_rsp[3].d_valid !== 1'b1) begin failures++; $display("FAIL same_both got ar=%b dv=%b exp 1 1", h_rsp[3].a_ready, h_rsp[3].d_valid); end
    tick();
    d_rsp.d_valid = 1'b0;
    h_req[3].a_valid = 1'b0;
    #1;
    checks++; if (full !== 4'b0) begin failures++; $display("FAIL same_hold got=%b exp=0000", full); end
    h_req[3].a_valid = 1'b1;
    tick();
    h_req[3].a_valid = 1'b0;
    #1;
    checks++; if (full !== 4'b1000) begin failures++; $display("FAIL same_count got=%b exp=1000", full); end
    clr_in();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    h_req[0].a_valid  = 1'b1;
    h_req[0].a_opcode = Get;
    d_rsp.a_ready = 1'b1;
    tick();
    tick();
    h_req[0].a_valid = 1'b0;
    h_req[2].a_valid  = 1'b1;
    h_req[2].a_opcode = Get;
    h_req[2].a_source = 8'h01;
    d_rsp.a_ready = 1'b0;
    #1;
    checks++; if (d_req.a_source !== 8'h81 || full !== 4'b0001) begin failures++; $display("FAIL rml_pre got src=%h full=%b exp src=81 full=0001", d_req.a_source, full); end
    tick();
    h_req[1].a_valid  = 1'b1;
    h_req[1].a_opcode = Get;
    d_rsp.d_valid  = 1'b1;
    d_rsp.d_source = 8'h80;
    #1;
    checks++; if (d_req.a_source !== 8'h81 || h_rsp[1].a_ready !== 1'b0) begin failures++; $display("FAIL rml_locked got src=%h h1=%b exp src=81 h1=0", d_req.a_source, h_rsp[1].a_ready); end
    rst = 1'b1;
    #1;
    checks++; if (d_req.a_valid !== 1'b0 || d_req.d_ready !== 1'b0 || full !== 4'b0) begin failures++; $display("FAIL rml_rst got av=%b dr=%b full=%b exp 0", d_req.a_valid, d_req.d_ready, full); end
    checks++; if (ar_vec() !== 4'b0 || dv_vec() !== 4'b0) begin failures++; $display("FAIL rml_rst_host got ar=%b dv=%b exp 0", ar_vec(), dv_vec()); end
    tick();
    rst = 1'b0;
    clr_in();
    for (int i = 0; i < 4; i++) begin
      h_req[i].a_valid  = 1'b1;
      h_req[i].a_opcode = Get;
    end
    d_rsp.a_ready = 1'b1;
    #1;
    checks++; if (d_req.a_source[7:6] !== 2'd0 || h_rsp[0].a_ready !== 1'b1) begin failures++; $display("FAIL rml_after got id=%0d ar0=%b exp id=0 ar0=1", d_req.a_source[7:6], h_rsp[0].a_ready); end
    tick();
    clr_in();
  endtask

  initial begin
    clr_in();
    test_reset();
    test_round_robin();
    test_lock();
    test_outs_limit();
    test_d_route();
    test_same_cycle();
    test_reset_mid_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
